// File: rtl/wddl_pkg.sv
// Shared types and constants for the WDDL phase checker and its jitter LFSR.
package wddl_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PRE  = 2'd1,
        EVAL = 2'd2,
        HALT = 2'd3
    } state_t;

    localparam int unsigned ERR_CNT_W = 4;
    localparam logic [ERR_CNT_W-1:0] ERR_CNT_MAX = ERR_CNT_W'(15);

    localparam int unsigned LFSR_W = 16;
    localparam logic [LFSR_W-1:0] LFSR_SEED = 16'hACE1;
    // Fibonacci taps 16,14,13,11 as bit positions 15,13,12,10
    localparam logic [LFSR_W-1:0] LFSR_TAPS = 16'hB400;

endpackage

// File: rtl/wddl_lfsr16.sv
// 16-bit Fibonacci LFSR driving the precharge jitter decision.
// Built only when WDDL_PHASE_JITTER_EN is defined.
`ifdef WDDL_PHASE_JITTER_EN
module wddl_lfsr16
    import wddl_pkg::*;
(
    input  logic CLK,
    input  logic Reset,
    output logic rnd
);

    logic [LFSR_W-1:0] lfsr;

    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            lfsr <= LFSR_SEED;
        end else begin
            lfsr <= {lfsr[LFSR_W-2:0], ^(lfsr & LFSR_TAPS)};
        end
    end

    assign rnd = lfsr[0];

endmodule
`endif

// File: rtl/wddl_phase_checker.sv
// Drives the WDDL precharge indicator and checks the returned dual-rail words.
// Optional random extra precharge cycles under WDDL_PHASE_JITTER_EN.
module wddl_phase_checker
    import wddl_pkg::*;
#(
    parameter int unsigned WIDTH      = 8,
    parameter int unsigned ERR_THRESH = 3
) (
    input  logic                 CLK,
    input  logic                 Reset,
    input  logic                 start,
    input  logic                 stop,
    output logic                 pc_ind,
    input  logic [WIDTH-1:0]     q_t,
    input  logic [WIDTH-1:0]     q_f,
    output logic [WIDTH-1:0]     data_out,
    output logic                 data_valid,
    output logic                 err_pulse,
    output logic [ERR_CNT_W-1:0] err_count,
    output logic                 alarm,
    output logic                 busy
);

    localparam logic [ERR_CNT_W-1:0] THRESH = ERR_CNT_W'(ERR_THRESH);

    state_t               state, state_next;
    logic                 phase_d, chk_d;
    logic                 stop_pend, stop_pend_next;
    logic                 fault_c, eval_ok_c, alarm_next;
    logic [ERR_CNT_W-1:0] cnt_next;

`ifdef WDDL_PHASE_JITTER_EN
    logic extra_pre, extra_pre_next, jitter_bit;

    wddl_lfsr16 u_lfsr (
        .CLK   (CLK),
        .Reset (Reset),
        .rnd   (jitter_bit)
    );

    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) extra_pre <= 1'b0;
        else       extra_pre <= extra_pre_next;
    end
`endif

    // Rail check against the phase the array was actually driven with
    always_comb begin
        fault_c = 1'b0;
        if (chk_d) begin
            if (phase_d) fault_c = ((q_t | q_f) != '0);
            else         fault_c = ((q_t ^ q_f) != '1);
        end
        eval_ok_c = chk_d && !phase_d && !fault_c;
        cnt_next  = err_count;
        if (fault_c && (err_count != ERR_CNT_MAX)) cnt_next = err_count + ERR_CNT_W'(1);
        alarm_next = alarm || (cnt_next >= THRESH);
    end

    always_comb begin
        state_next     = state;
        stop_pend_next = stop_pend | stop;
`ifdef WDDL_PHASE_JITTER_EN
        extra_pre_next = extra_pre;
`endif
        case (state)
            IDLE: begin
                stop_pend_next = start & stop;
                if (start) state_next = PRE;
            end
            PRE: begin
`ifdef WDDL_PHASE_JITTER_EN
                if (jitter_bit && !extra_pre) begin
                    extra_pre_next = 1'b1;
                end else begin
                    extra_pre_next = 1'b0;
                    state_next     = EVAL;
                end
`else
                state_next = EVAL;
`endif
            end
            EVAL: begin
                if (stop_pend | stop) begin
                    state_next     = IDLE;
                    stop_pend_next = 1'b0;
                end else begin
                    state_next = PRE;
                end
            end
            HALT:    stop_pend_next = 1'b0;
            default: state_next = IDLE;
        endcase
        // Alarm overrides every other transition
        if (alarm_next) state_next = HALT;
    end

    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) state <= IDLE;
        else       state <= state_next;
    end

    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            pc_ind     <= 1'b1;
            busy       <= 1'b0;
            phase_d    <= 1'b1;
            chk_d      <= 1'b0;
            stop_pend  <= 1'b0;
            data_out   <= '0;
            data_valid <= 1'b0;
            err_pulse  <= 1'b0;
            err_count  <= '0;
            alarm      <= 1'b0;
        end else begin
            pc_ind     <= (state_next != EVAL);
            busy       <= (state_next == PRE) || (state_next == EVAL);
            phase_d    <= pc_ind;
            chk_d      <= (state == PRE) || (state == EVAL);
            stop_pend  <= stop_pend_next;
            data_valid <= eval_ok_c && !alarm_next;
            if (eval_ok_c && !alarm_next) data_out <= q_t;
            err_pulse  <= fault_c;
            err_count  <= cnt_next;
            alarm      <= alarm_next;
        end
    end

endmodule

// File: tb/tb_wddl_phase_checker.sv
// Directed bench for wddl_phase_checker with a behavioural dual-rail array model.
module tb_wddl_phase_checker;

    logic       CLK = 1'b0;
    logic       Reset, start, stop;
    logic       pc_ind, data_valid, err_pulse, alarm, busy;
    logic [7:0] q_t, q_f, data_out;
    logic [3:0] err_count;

    int n_cmp = 0;
    int n_err = 0;

    logic       pc_prev;
    logic [7:0] ev_word, inj_t, inj_f;
    logic       inj_en;
    int         n_eval, n_dv, pre_run, max_run, n_fault;

    always #5 CLK = ~CLK;

    wddl_phase_checker #(.WIDTH(8), .ERR_THRESH(3)) dut (
        .CLK        (CLK),
        .Reset      (Reset),
        .start      (start),
        .stop       (stop),
        .pc_ind     (pc_ind),
        .q_t        (q_t),
        .q_f        (q_f),
        .data_out   (data_out),
        .data_valid (data_valid),
        .err_pulse  (err_pulse),
        .err_count  (err_count),
        .alarm      (alarm),
        .busy       (busy)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // One clock; array presents the phase that pc_ind held during the previous cycle
    task automatic tick();
        pc_prev = pc_ind;
        @(posedge CLK);
        #1;
        if (pc_prev) begin
            q_t = '0;
            q_f = '0;
        end else begin
            q_t = ev_word;
            q_f = ~ev_word;
        end
        if (inj_en) begin
            q_t = inj_t;
            q_f = inj_f;
        end
    endtask

    task automatic run_obs();
        tick();
        if (busy && pc_ind) begin
            pre_run++;
            if (pre_run > max_run) max_run = pre_run;
        end else begin
            pre_run = 0;
        end
        if (!pc_ind) n_eval++;
        if (data_valid) begin
            n_dv++;
            chk("run_dout", 32'(data_out), 32'h5A);
        end
        if (err_pulse) n_fault++;
    endtask

    initial begin
        Reset = 1'b1; start = 1'b0; stop = 1'b0;
        q_t = '0; q_f = '0; ev_word = '0;
        inj_en = 1'b0; inj_t = '0; inj_f = '0;
        n_eval = 0; n_dv = 0; pre_run = 0; max_run = 0; n_fault = 0;
        repeat (3) @(posedge CLK);
        #1;
        chk("rst_pc", 32'(pc_ind), 1);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_dv", 32'(data_valid), 0);
        chk("rst_ep", 32'(err_pulse), 0);
        chk("rst_cnt", 32'(err_count), 0);
        chk("rst_alarm", 32'(alarm), 0);
        chk("rst_dout", 32'(data_out), 0);
        Reset = 1'b0;

`ifndef WDDL_PHASE_JITTER_EN
        // Clean alternation carrying A5 then 3C
        start = 1'b1; tick(); start = 1'b0;
        chk("start_busy", 32'(busy), 1);
        chk("start_pc", 32'(pc_ind), 1);
        tick();
        chk("eval1_pc", 32'(pc_ind), 0);
        ev_word = 8'hA5; tick();
        chk("pre2_pc", 32'(pc_ind), 1);
        chk("pre2_dv", 32'(data_valid), 0);
        tick();
        chk("a5_dv", 32'(data_valid), 1);
        chk("a5_dout", 32'(data_out), 32'hA5);
        chk("a5_pc", 32'(pc_ind), 0);
        chk("a5_cnt", 32'(err_count), 0);
        ev_word = 8'h3C; tick();
        chk("pre3_pc", 32'(pc_ind), 1);
        chk("pre3_dv", 32'(data_valid), 0);
        tick();
        chk("3c_dv", 32'(data_valid), 1);
        chk("3c_dout", 32'(data_out), 32'h3C);
        chk("3c_ep", 32'(err_pulse), 0);

        // Non-complementary evaluate word
        inj_en = 1'b1; inj_t = 8'h01; inj_f = 8'h01; tick(); inj_en = 1'b0;
        chk("inj_pc", 32'(pc_ind), 1);
        tick();
        chk("evf_ep", 32'(err_pulse), 1);
        chk("evf_cnt", 32'(err_count), 1);
        chk("evf_dv", 32'(data_valid), 0);
        chk("evf_alarm", 32'(alarm), 0);
        chk("evf_pc", 32'(pc_ind), 0);
        chk("evf_dout_kept", 32'(data_out), 32'h3C);
        ev_word = 8'h69; tick();
        chk("evf_ep_clr", 32'(err_pulse), 0);
        tick();
        chk("rec_dv", 32'(data_valid), 1);
        chk("rec_dout", 32'(data_out), 32'h69);

        // Stop raised during PRE: current pair completes, then idle
        tick();
        chk("stp_pre_pc", 32'(pc_ind), 1);
        stop = 1'b1; tick(); stop = 1'b0;
        chk("stp_eval_pc", 32'(pc_ind), 0);
        chk("stp_eval_busy", 32'(busy), 1);
        ev_word = 8'hC3; tick();
        chk("stp_idle_busy", 32'(busy), 0);
        chk("stp_idle_pc", 32'(pc_ind), 1);
        tick();
        chk("stp_dv", 32'(data_valid), 1);
        chk("stp_dout", 32'(data_out), 32'hC3);
        tick();
        chk("stp_dv_end", 32'(data_valid), 0);
        chk("stp_busy_end", 32'(busy), 0);

        // Start and stop together in IDLE: one PRE/EVAL pair
        start = 1'b1; stop = 1'b1; tick(); start = 1'b0; stop = 1'b0;
        chk("ss_busy", 32'(busy), 1);
        tick();
        chk("ss_eval_pc", 32'(pc_ind), 0);
        ev_word = 8'h96; tick();
        chk("ss_idle_busy", 32'(busy), 0);
        chk("ss_idle_pc", 32'(pc_ind), 1);
        tick();
        chk("ss_dv", 32'(data_valid), 1);
        chk("ss_dout", 32'(data_out), 32'h96);
        tick();
        chk("ss_dv_end", 32'(data_valid), 0);

        // Second fault then asynchronous reset mid-EVAL
        start = 1'b1; tick(); start = 1'b0;
        tick();
        inj_en = 1'b1; inj_t = 8'h01; inj_f = 8'h01; tick(); inj_en = 1'b0;
        tick();
        chk("mid_cnt", 32'(err_count), 2);
        chk("mid_pc", 32'(pc_ind), 0);
        Reset = 1'b1; #1;
        chk("mrst_pc", 32'(pc_ind), 1);
        chk("mrst_busy", 32'(busy), 0);
        chk("mrst_cnt", 32'(err_count), 0);
        chk("mrst_dout", 32'(data_out), 0);
        chk("mrst_dv", 32'(data_valid), 0);
        Reset = 1'b0;

        // Three precharge faults latch the alarm
        start = 1'b1; tick(); start = 1'b0;
        chk("res_busy", 32'(busy), 1);
        chk("res_cnt", 32'(err_count), 0);
        inj_en = 1'b1; inj_t = 8'h80; inj_f = 8'h00; tick(); inj_en = 1'b0;
        ev_word = 8'h11; tick();
        chk("pf1_ep", 32'(err_pulse), 1);
        chk("pf1_cnt", 32'(err_count), 1);
        inj_en = 1'b1; tick(); inj_en = 1'b0;
        chk("pf1_dv", 32'(data_valid), 1);
        tick();
        chk("pf2_cnt", 32'(err_count), 2);
        chk("pf2_alarm", 32'(alarm), 0);
        inj_en = 1'b1; tick(); inj_en = 1'b0;
        tick();
        chk("pf3_cnt", 32'(err_count), 3);
        chk("pf3_alarm", 32'(alarm), 1);
        chk("pf3_pc", 32'(pc_ind), 1);
        chk("pf3_busy", 32'(busy), 0);
        start = 1'b1; tick(); start = 1'b0;
        chk("halt_dv", 32'(data_valid), 0);
        chk("halt_cnt", 32'(err_count), 3);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("halt_pc", 32'(pc_ind), 1);
            chk("halt_dv_hold", 32'(data_valid), 0);
            chk("halt_alarm", 32'(alarm), 1);
        end
        Reset = 1'b1; #2;
        chk("clr_alarm", 32'(alarm), 0);
        chk("clr_cnt", 32'(err_count), 0);
        Reset = 1'b0;
`endif

        // Long clean run: PRE run lengths and one data_valid per EVAL
        ev_word = 8'h5A; inj_en = 1'b0;
        start = 1'b1; run_obs(); start = 1'b0;
        repeat (199) run_obs();
        stop = 1'b1; run_obs(); stop = 1'b0;
        repeat (8) run_obs();
        chk("run_faults", 32'(n_fault), 0);
        chk("run_err_count", 32'(err_count), 0);
        chk("run_dv_per_eval", 32'(n_dv), 32'(n_eval));
        chk("run_evals_seen", 32'(n_eval > 50), 1);
        chk("run_busy_end", 32'(busy), 0);
`ifdef WDDL_PHASE_JITTER_EN
        chk("run_max_pre", 32'(max_run), 2);
`else
        chk("run_max_pre", 32'(max_run), 1);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/wddl_phase_checker.md
Name: wddl_phase_checker

Overview:
- Downstream companion of the dual-rail (WDDL) sampling register array, with the array's WIDTH bit pairs connected to q_t/q_f.
- Drives the array's precharge indicator (pc_ind), alternating precharge and evaluate cycles.
- Consumes the array's true/false rail outputs and checks them: precharge must be all-zero, evaluate must be complementary.
- Converts valid evaluate words to single-rail data and raises a sticky alarm on repeated rail faults (fault-injection / glitch detection).

Parameters:
- WIDTH, 8, number of dual-rail bit pairs checked.
- ERR_THRESH, 3, rail-fault count at which the alarm latches (1..15).

Ports:
- CLK  input  1  clock
- Reset  input  1  reset, asynchronous, active-high
- start  input  1  one-cycle request to begin alternating phases
- stop  input  1  one-cycle request to return to idle
- pc_ind  output  1  precharge indicator to the sampling array: 1 = precharge, 0 = evaluate
- q_t  input  WIDTH  true rails from the sampling array
- q_f  input  WIDTH  false rails from the sampling array
- data_out  output  WIDTH  single-rail word (q_t of a valid evaluate cycle)
- data_valid  output  1  one-cycle strobe qualifying data_out
- err_pulse  output  1  one-cycle strobe on any rail fault
- err_count  output  4  saturating fault counter
- alarm  output  1  sticky fault alarm; cleared only by Reset
- busy  output  1  high in PRE/EVAL states

Behaviour:
- Reset values: state = IDLE, pc_ind = 1, data_out = 0, data_valid = 0, err_pulse = 0, err_count = 0, alarm = 0, busy = 0, internal phase_d = 1, chk_d = 0.
- All state is registered on posedge CLK with async clear. Outputs are registered; there are no combinational input-to-output paths.
- FSM states: IDLE, PRE, EVAL, HALT.
  - IDLE: pc_ind = 1. On start, go to PRE.
  - PRE: pc_ind = 1. Go to EVAL.
  - EVAL: pc_ind = 0. If stop was seen (stop latched in a pending flag, even if it arrived during PRE), go to IDLE and clear the flag; else go to PRE.
  - HALT: pc_ind = 1 forever, data_valid held 0. Exit only via Reset.
  - Any state except HALT goes to HALT on the cycle alarm sets; this has priority over every other transition.
- start while busy: ignored. start and stop in the same IDLE cycle: start wins; stop is then pending, so the sequence is PRE, EVAL, IDLE.
- Phase alignment: the array outputs at cycle n+1 the phase driven on pc_ind at cycle n.
  - phase_d <= pc_ind each cycle.
  - chk_d <= (state is PRE or EVAL), i.e. checking is enabled one cycle after busy.
- Checks, active only when chk_d = 1:
  - phase_d = 1: fault if (q_t | q_f) != 0.
  - phase_d = 0: fault if (q_t ^ q_f) != all-ones.
  - phase_d = 0 and no fault: data_out <= q_t and data_valid = 1 on the next cycle. A faulty evaluate word never produces data_valid; data_out keeps its previous value.
- On fault, err_pulse = 1 on the next cycle and err_count increments, saturating at 15.
- alarm sets in the same cycle err_count becomes >= ERR_THRESH.
- Latency: pc_ind = 0 at cycle n, array rails at n+1, data_valid/err_pulse at n+2.
- Reset mid-operation: everything returns to reset values immediately, including alarm and err_count.

Optional Feature:
- Macro WDDL_PHASE_JITTER_EN.
- Defined:
  - A 16-bit Fibonacci LFSR (taps 16,14,13,11; seed 16'hACE1 on Reset) advances every cycle.
  - On leaving PRE, if lfsr[0] = 1 the FSM spends exactly one extra PRE cycle; at most one extra per phase.
  - Desynchronises evaluate timing against power/EM traces.
  - Checks remain correct because they key on phase_d.
- Not defined: strict PRE/EVAL alternation, no LFSR logic instantiated.

Decomposition:
- Package wddl_pkg holds:
  - state enum (IDLE, PRE, EVAL, HALT)
  - ERR_CNT_W = 4, ERR_CNT_MAX = 15
  - LFSR_SEED = 16'hACE1 and the tap mask
- One sub-module, wddl_lfsr16, instantiated only under WDDL_PHASE_JITTER_EN.

Test Plan:
- Reset, start, then a model array returns 00 pairs in precharge and complementary pairs carrying data 8'hA5, 8'h3C in evaluate. Expect pc_ind = 1,0,1,0; data_valid pulses with data_out = A5 then 3C, each 2 cycles after its pc_ind = 0; err_count = 0.
- Inject q_t = q_f = 8'h01 in one evaluate cycle. Expect err_pulse one cycle later, err_count = 1, no data_valid for that word, alarm = 0, alternation continues.
- Inject 8'h80 on q_t during 3 precharge cycles. Expect err_count = 3, alarm = 1, state HALT, pc_ind stuck at 1, no further data_valid.
- Assert stop during PRE. Expect the following EVAL to complete with data_valid, then IDLE, busy = 0, pc_ind = 1; a start in the same cycle as stop during IDLE yields one PRE/EVAL pair.
- Assert Reset mid-EVAL with err_count = 2. Expect all outputs at reset values immediately; after release, start resumes with err_count = 0.
- With WDDL_PHASE_JITTER_EN defined, run 200 cycles. Expect some doubled PRE cycles, never tripled; zero faults and a data_valid for every EVAL.
